cpu_phase_seq: RTL and testbench

- Parametrised instruction-phase sequencer for the MU0 CPU control path. Successor to the fixed fetch/exec1/exec2 state decoder.
- Generates one-hot fetch and exec-phase strobes from a registered state.
- Adds a variable per-instruction exec length, a stall hold, instruction-boundary halt/resume, and an instruction-complete pulse.
- Sits between the instruction decoder (which supplies the exec length) and the datapath enables.

---
 rtl/cpu_phase_seq.sv | 129 ++++++++++++
 tb/tb_cpu_phase_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_seq.sv
// ============================================================================
// Module   : cpu_phase_seq
// Brief    : MU0 instruction-phase sequencer: FETCH, variable-length EXEC
//            phases, stall hold, boundary halt/resume, instr-complete pulse.
//            Optional retired-instruction counter: CPU_PHASE_SEQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_phase_seq #(
  parameter int MAX_EXEC = 2,
  parameter int LEN_W    = $clog2(MAX_EXEC + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [LEN_W-1:0]    n_exec,
  input  logic                halt_req,
  input  logic                resume,
  output logic                fetch,
  output logic [MAX_EXEC-1:0] exec,
  output logic [LEN_W-1:0]    phase,
  output logic                halted,
  output logic                instr_done,
  output logic [31:0]         instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(MAX_EXEC);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_idx, w_idx_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_idx   <= '0;
      r_len   <= C_LEN_ONE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Final exec phase completing this cycle; a stall holds it instead.
  assign w_last = (r_state == S_EXEC) && (r_idx == r_len) && !stall;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_len_clamped = n_exec;
    if (n_exec == '0) begin
      w_len_clamped = C_LEN_ONE;
    end else if (n_exec > C_LEN_MAX) begin
      w_len_clamped = C_LEN_MAX;
    end

    case (r_state)
      S_FETCH: begin
        if (!stall) begin
          w_len_nxt   = w_len_clamped;
          w_idx_nxt   = C_LEN_ONE;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (r_idx < r_len) begin
            w_idx_nxt = r_idx + C_LEN_ONE;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = halt_req ? S_HALT : S_FETCH;
          end
        end
      end
      S_HALT: begin
        w_idx_nxt = '0;
        if (resume) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign fetch      = (r_state == S_FETCH);
  assign halted     = (r_state == S_HALT);
  assign phase      = (r_state == S_EXEC) ? r_idx : '0;
  assign instr_done = w_last;

  generate
    for (genvar k = 0; k < MAX_EXEC; k++) begin : g_exec
      assign exec[k] = (r_state == S_EXEC) && (r_idx == LEN_W'(k + 1));
    end
  endgenerate

`ifdef CPU_PHASE_SEQ_PERF_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (w_last && (r_instr_count != 32'hFFFF_FFFF)) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_phase_seq.sv
// ============================================================================
// Module   : tb_cpu_phase_seq
// Brief    : Directed self-checking bench for cpu_phase_seq (MAX_EXEC=2 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_phase_seq;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  n_exec;
  logic        halt_req;
  logic        resume;
  logic        fetch;
  logic [1:0]  exec;
  logic [1:0]  phase;
  logic        halted;
  logic        instr_done;
  logic [31:0] instr_count;

  logic        rst_n_b;
  logic [2:0]  n_exec_b;
  logic        fetch_b;
  logic [3:0]  exec_b;
  logic [2:0]  phase_b;
  logic        halted_b;
  logic        instr_done_b;
  logic [31:0] instr_count_b;

  int checks   = 0;
  int failures = 0;

  cpu_phase_seq #(.MAX_EXEC(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .n_exec      (n_exec),
    .halt_req    (halt_req),
    .resume      (resume),
    .fetch       (fetch),
    .exec        (exec),
    .phase       (phase),
    .halted      (halted),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  cpu_phase_seq #(.MAX_EXEC(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n_b),
    .stall       (1'b0),
    .n_exec      (n_exec_b),
    .halt_req    (1'b0),
    .resume      (1'b0),
    .fetch       (fetch_b),
    .exec        (exec_b),
    .phase       (phase_b),
    .halted      (halted_b),
    .instr_done  (instr_done_b),
    .instr_count (instr_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {fetch, halted, instr_done, exec, phase} of the MAX_EXEC=2 instance.
  task automatic chk_a(input string tag, input logic f, input logic h, input logic d,
                       input logic [1:0] e, input logic [1:0] p);
    chk(tag, {27'd0, fetch, halted, instr_done, exec, phase},
             {27'd0, f, h, d, e, p});
  endtask

  task automatic chk_b(input string tag, input logic f, input logic d,
                       input logic [3:0] e, input logic [2:0] p);
    chk(tag, {23'd0, fetch_b, halted_b, instr_done_b, exec_b, phase_b},
             {23'd0, f, 1'b0, d, e, p});
  endtask

  initial begin
    rst_n    = 1'b0;
    rst_n_b  = 1'b0;
    stall    = 1'b0;
    n_exec   = 2'd1;
    halt_req = 1'b0;
    resume   = 1'b0;
    n_exec_b = 3'd0;

    #3;
    chk_a("reset_outputs", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
    chk("reset_count", instr_count, 32'd0);

    tick();
    rst_n = 1'b1;
    chk_a("post_release_fetch", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);

    // Single-phase instructions: 0,1,0,1,... with instr_done on every phase 1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("len1_exec1", 1'b0, 1'b0, 1'b1, 2'b01, 2'd1);
      tick();
      chk_a("len1_fetch", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
    end

    // Two-phase instruction, stalled 3 cycles in EXEC(1)
    n_exec = 2'd2;
    tick();
    stall = 1'b1;
    #1;
    chk_a("stall_exec1_a", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);
    tick();
    chk_a("stall_exec1_b", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);
    tick();
    chk_a("stall_exec1_c", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);
    tick();
    stall = 1'b0;
    #1;
    chk_a("stall_exec1_d", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);
    tick();
    chk_a("len2_exec2", 1'b0, 1'b0, 1'b1, 2'b10, 2'd2);
    // Stall on final phase wins over instr_done and halt_req
    stall    = 1'b1;
    halt_req = 1'b1;
    #1;
    chk_a("stall_final_nodone", 1'b0, 1'b0, 1'b0, 2'b10, 2'd2);
    tick();
    chk_a("stall_final_held", 1'b0, 1'b0, 1'b0, 2'b10, 2'd2);
    stall    = 1'b0;
    halt_req = 1'b0;
    #1;
    chk_a("stall_final_release", 1'b0, 1'b0, 1'b1, 2'b10, 2'd2);
    tick();
    chk_a("len2_back_fetch", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);

    // Halt requested mid-EXEC(1), held to boundary
    tick();
    halt_req = 1'b1;
    chk_a("halt_exec1", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);
    tick();
    chk_a("halt_exec2_done", 1'b0, 1'b0, 1'b1, 2'b10, 2'd2);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_a("halted_hold", 1'b0, 1'b1, 1'b0, 2'b00, 2'd0);
      tick();
    end
    stall    = 1'b0;
    halt_req = 1'b0;
    resume   = 1'b1;
    chk_a("halted_before_resume", 1'b0, 1'b1, 1'b0, 2'b00, 2'd0);
    tick();
    chk_a("resume_fetch", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
    // resume held while in FETCH has no effect
    tick();
    resume = 1'b0;
    chk_a("resume_ignored", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);

    // Halt request withdrawn before the boundary is lost
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    #1;
    chk_a("lost_halt_exec2", 1'b0, 1'b0, 1'b1, 2'b10, 2'd2);
    tick();
    chk_a("lost_halt_fetch", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);

    // Asynchronous reset mid-EXEC(2)
    tick();
    tick();
    chk_a("pre_reset_exec2", 1'b0, 1'b0, 1'b1, 2'b10, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_reset", 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
    chk("async_reset_count", instr_count, 32'd0);
    rst_n  = 1'b1;
    n_exec = 2'd2;
    tick();
    chk_a("post_reset_exec1", 1'b0, 1'b0, 1'b0, 2'b01, 2'd1);
    tick();
    chk_a("post_reset_exec2", 1'b0, 1'b0, 1'b1, 2'b10, 2'd2);
    tick();

    // Ten single-phase instructions from a fresh reset
    #2;
    rst_n = 1'b0;
    #2;
    rst_n  = 1'b1;
    n_exec = 2'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tick();
    end
`ifdef CPU_PHASE_SEQ_PERF_EN
    chk("count_ten", instr_count, 32'd10);
`else
    chk("count_tied_zero", instr_count, 32'd0);
`endif

    // MAX_EXEC=4: n_exec=0 clamps to 1, n_exec=7 clamps to 4
    #2;
    rst_n_b = 1'b1;
    chk_b("b_fetch0", 1'b1, 1'b0, 4'b0000, 3'd0);
    tick();
    n_exec_b = 3'd7;
    chk_b("b_len0_exec1", 1'b0, 1'b1, 4'b0001, 3'd1);
    tick();
    chk_b("b_fetch1", 1'b1, 1'b0, 4'b0000, 3'd0);
    tick();
    chk_b("b_len7_exec1", 1'b0, 1'b0, 4'b0001, 3'd1);
    tick();
    chk_b("b_len7_exec2", 1'b0, 1'b0, 4'b0010, 3'd2);
    tick();
    chk_b("b_len7_exec3", 1'b0, 1'b0, 4'b0100, 3'd3);
    tick();
    chk_b("b_len7_exec4", 1'b0, 1'b1, 4'b1000, 3'd4);
    tick();
    chk_b("b_fetch2", 1'b1, 1'b0, 4'b0000, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
